// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with valid/ready handshakes.
// Single-cycle logic ops plus iterative shift-add MUL and restoring DIV.
module seq_alu #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             illegal_operation,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic            div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            ill_q, ill_d;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH:0]   mul_hi;
  logic [W2-1:0]    mul_nxt;
  logic [WIDTH:0]   div_top;
  logic [WIDTH:0]   div_dif;
  logic             div_ge;
  logic [W2-1:0]    div_nxt;
  logic [W2-1:0]    step_nxt;

  assign sum = a + b;
  assign dif = a - b;

  // Shift-add: accumulate multiplicand into the top half, shift right.
  assign mul_hi  = {1'b0, acc_q[W2-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_nxt = {mul_hi, acc_q[WIDTH-1:1]};

  // Restoring divide: remainder in top half, quotient shifts into bottom.
  assign div_top = acc_q[W2-1:WIDTH-1];
  assign div_dif = div_top - {1'b0, opnd_q};
  assign div_ge  = ~div_dif[WIDTH];
  assign div_nxt = div_ge
                 ? {div_dif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                 : {acc_q[W2-2:0], 1'b0};

  assign step_nxt = div_q ? div_nxt : mul_nxt;

  assign in_ready          = (state_q == S_IDLE);
  assign busy              = (state_q == S_BUSY);
  assign out_valid         = (state_q == S_DONE);
  assign result            = res_q;
  assign overflow          = ovf_q;
  assign illegal_operation = ill_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  // Next-state: accept/decode, iterate, then hold until handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DONE;
          res_d   = '0;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
          unique case (opcode)
            3'b000: begin
              res_d = sum;
              ovf_d = (a[WIDTH-1] == b[WIDTH-1])
                    & (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
              res_d = dif;
              ovf_d = (a[WIDTH-1] != b[WIDTH-1])
                    & (dif[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010: res_d = a & b;
            3'b011: res_d = a | b;
            3'b100: res_d = a ^ b;
            3'b101: begin
              state_d = S_BUSY;
              acc_d   = {{WIDTH{1'b0}}, b};
              opnd_d  = a;
              div_d   = 1'b0;
              cnt_d   = '0;
            end
            3'b110: begin
              if (b == '0) begin
                ill_d = 1'b1;
              end else begin
                state_d = S_BUSY;
                acc_d   = {{WIDTH{1'b0}}, a};
                opnd_d  = b;
                div_d   = 1'b1;
                cnt_d   = '0;
              end
            end
            3'b111: ill_d = 1'b1;
          endcase
        end
      end
      S_BUSY: begin
        acc_d = step_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          res_d   = step_nxt[WIDTH-1:0];
          ovf_d   = div_q ? 1'b0 : (|mul_nxt[W2-1:WIDTH]);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          res_d   = '0;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors for seq_alu at WIDTH=5.
// Expected values below are hand-computed.
module tb_seq_alu;

  localparam int W = 5;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         illegal_operation;
  logic         busy;

  int n_vec;
  int n_bad;

  seq_alu #(.WIDTH(W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .a                 (a),
    .b                 (b),
    .opcode            (opcode),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .result            (result),
    .overflow          (overflow),
    .illegal_operation (illegal_operation),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one op from a negedge; returns at a negedge after handshake.
  task automatic run_op(input string tag,
                        input logic [W-1:0] ia,
                        input logic [W-1:0] ib,
                        input logic [2:0] op,
                        input logic [W-1:0] er,
                        input logic eo,
                        input logic ei,
                        input int elat,
                        input int hold);
    int lat;
    int bcnt;
    chk({tag, ".rdy"}, in_ready, 1);
    a        = ia;
    b        = ib;
    opcode   = op;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    opcode   = 3'($urandom);
    lat  = 1;
    bcnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".busy"}, bcnt, elat - 1);
    chk({tag, ".res"}, result, er);
    chk({tag, ".ovf"}, overflow, eo);
    chk({tag, ".ill"}, illegal_operation, ei);
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      @(negedge clk);
      chk({tag, ".hv"}, out_valid, 1);
      chk({tag, ".hr"}, result, er);
      chk({tag, ".ho"}, overflow, eo);
      chk({tag, ".hi"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".idle"}, in_ready, 1);
    chk({tag, ".ov0"}, out_valid, 0);
    chk({tag, ".il0"}, illegal_operation, 0);
  endtask

  initial begin
    int seen;
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a         = 5'd3;
    b         = 5'd4;
    opcode    = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy", in_ready, 1);
    chk("rst.ov", out_valid, 0);
    chk("rst.res", result, 0);
    chk("rst.busy", busy, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("rst.nocap", out_valid, 0);

    run_op("add_ovf", 5'b01111, 5'b00001, 3'b000, 5'b10000, 1, 0, 1, 0);
    run_op("add",     5'b00011, 5'b00100, 3'b000, 5'b00111, 0, 0, 1, 0);
    run_op("add_neg", 5'b10000, 5'b10000, 3'b000, 5'b00000, 1, 0, 1, 0);
    run_op("sub_bp",  5'b10000, 5'b00001, 3'b001, 5'b01111, 1, 0, 1, 10);
    run_op("sub_ovf", 5'b01111, 5'b11111, 3'b001, 5'b10000, 1, 0, 1, 0);
    run_op("and",     5'd22,    5'd12,    3'b010, 5'd4,     0, 0, 1, 0);
    run_op("or",      5'd22,    5'd12,    3'b011, 5'd30,    0, 0, 1, 0);
    run_op("xor",     5'd22,    5'd12,    3'b100, 5'd26,    0, 0, 1, 0);
    run_op("mul75",   5'd7,     5'd5,     3'b101, 5'd3,     1, 0, 6, 0);
    run_op("mul35",   5'd3,     5'd5,     3'b101, 5'd15,    0, 0, 6, 0);
    run_op("mulmax",  5'd31,    5'd31,    3'b101, 5'd1,     1, 0, 6, 2);
    run_op("div234",  5'd23,    5'd4,     3'b110, 5'd5,     0, 0, 6, 0);
    run_op("div311",  5'd31,    5'd1,     3'b110, 5'd31,    0, 0, 6, 0);
    run_op("div49",   5'd4,     5'd9,     3'b110, 5'd0,     0, 0, 6, 0);
    run_op("div0",    5'd9,     5'd0,     3'b110, 5'd0,     0, 1, 1, 0);
    run_op("op111",   5'd5,     5'd3,     3'b111, 5'd0,     0, 1, 1, 0);

    a        = 5'd7;
    b        = 5'd5;
    opcode   = 3'b101;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mrst.busy1", busy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst.busy", busy, 0);
    chk("mrst.rdy", in_ready, 1);
    rst_n = 1'b1;
    seen  = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mrst.noval", seen, 0);
    run_op("add22", 5'd2, 5'd2, 3'b000, 5'd4, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
